tri_bus_arbiter: RTL and testbench

Round-robin arbiter that owns the output enables of N tri-state buffers sharing one bus wire. Each cycle it grants at most one requester. Between owners it inserts a fixed number of all-disabled turnaround cycles so that two buffers never drive the bus at once. Its `en` outputs connect directly to the `en` inputs of the tri-state buffer stage downstream.

---
 rtl/tri_bus_pkg.sv | 21 ++
 rtl/tri_bus_arbiter_rr_pick.sv | 38 +++
 rtl/tri_bus_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_tri_bus_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/tri_bus_pkg.sv
// Shared types and constants for the tri-state bus arbiter.
// Holds the FSM state encoding, counter widths and the owner-index width helper.
package tri_bus_pkg;

    // Arbiter FSM states: no owner, one owner driving, or all-off turnaround.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_TURN = 2'd2
    } tri_bus_state_e;

    // Turnaround counter holds 1..15, hold counter holds 1..255.
    localparam int TURN_W = 4;
    localparam int HOLD_W = 8;

    // Width of an index into N requesters; never narrower than one bit.
    function automatic int owner_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tri_bus_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Scans the eligible vector starting at the pointer position and wrapping
// around; the first set bit found wins. Produces the one-hot winner, its
// index and a flag saying whether anything was eligible at all.
module rr_pick
    import tri_bus_pkg::*;
#(
    parameter int N = 4,
    localparam int OW = owner_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [OW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [OW-1:0] idx_o,
    output logic          any_o
);

    logic [OW-1:0] pos;
    logic          found;

    // Walk the requesters in priority order ptr, ptr+1, ... wrapping at N.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        pos     = '0;
        for (int i = 0; i < N; i++) begin
            pos = OW'((int'(ptr_i) + i) % N);
            if (!found && req_i[pos]) begin
                found        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = pos;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of the output enables of N tri-state buffers on one wire.
//
// At most one enable is ever high. Between two owners the arbiter always
// passes through TURN consecutive all-off cycles, so two buffers can never
// fight over the wire. An owner keeps the bus while its request stays high,
// up to MAX_HOLD cycles (0 = no limit); an owner cut off by the hold limit
// gets a one-cycle timeout pulse and is masked until it drops its request.
//
// Every output comes straight from a flop, so en has no combinational path
// from req, and the asynchronous reset clears the enables without a clock.
//
// Request handshake: a requester raises req and holds it for as long as it
// wants the bus; the grant is seen as its en bit going high one edge later;
// it gives the bus back by lowering req, which is acted on at the next edge.
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int N        = 4,   // requesters, 2..16
    parameter int TURN     = 1,   // turnaround cycles, 1..15
    parameter int MAX_HOLD = 16,  // hold limit in cycles, 0..255, 0 = unlimited
    localparam int OW      = owner_width(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   en,
    output logic [OW-1:0]  owner,
    output logic           bus_busy,
    output logic           timeout,
    output tri_bus_state_e dbg_state
);

    localparam logic              HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURN);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD);
    localparam logic [OW-1:0]     LAST_IDX  = OW'(N - 1);

    tri_bus_state_e    state_q, state_d;
    logic [N-1:0]      en_q, en_d;
    logic [N-1:0]      mask_q, mask_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [OW-1:0]     ptr_q, ptr_d;
    logic [TURN_W-1:0] turn_q, turn_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic [N-1:0]      elig;
    logic [N-1:0]      win_grant;
    logic [OW-1:0]     win_idx;
    logic              win_any;
    logic [OW-1:0]     ptr_after_owner;
    logic              owner_req;
    logic              hold_expired;

    // A requester cut off by the hold limit stays out of arbitration until
    // it has been seen with req low at least once.
    assign elig = req & ~mask_q;

    // Next arbitration starts just past the owner that is leaving.
    assign ptr_after_owner = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

    assign owner_req    = req[owner_q];
    assign hold_expired = HOLD_EN && (hold_q == HOLD_LAST);

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .req_i   (elig),
        .ptr_i   (ptr_q),
        .grant_o (win_grant),
        .idx_o   (win_idx),
        .any_o   (win_any)
    );

    // State and datapath registers; reset drops every enable immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            en_q      <= '0;
            mask_q    <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            turn_q    <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            mask_q    <= mask_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            turn_q    <= turn_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state and next-register logic for grant, hold, release and turnaround.
    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        turn_d    = turn_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        // Seeing req low once clears a requester's timeout mask.
        mask_d    = mask_q & req;

        unique case (state_q)
            ST_IDLE: begin
                if (win_any) begin
                    state_d = ST_OWN;
                    en_d    = win_grant;
                    owner_d = win_idx;
                    busy_d  = 1'b1;
                    hold_d  = HOLD_W'(1);
                end
            end

            ST_OWN: begin
                if (!owner_req || hold_expired) begin
                    // Owner leaves: either it let go, or the hold limit ran out.
                    // Letting go on the limiting edge counts as a plain release.
                    state_d = ST_TURN;
                    en_d    = '0;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_after_owner;
                    turn_d  = TURN_W'(1);
                    hold_d  = '0;
                    if (owner_req) begin
                        timeout_d       = 1'b1;
                        mask_d[owner_q] = 1'b1;
                    end
                end else if (HOLD_EN) begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            ST_TURN: begin
                if (turn_q == TURN_LAST) begin
                    // Last all-off cycle ends here: hand over directly or go idle.
                    turn_d = '0;
                    if (win_any) begin
                        state_d = ST_OWN;
                        en_d    = win_grant;
                        owner_d = win_idx;
                        busy_d  = 1'b1;
                        hold_d  = HOLD_W'(1);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    turn_d = turn_q + TURN_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
                en_d    = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Outputs are taken directly from registers.
    always_comb begin
        en        = en_q;
        owner     = owner_q;
        bus_busy  = busy_q;
        timeout   = timeout_q;
        dbg_state = state_q;
    end

`ifndef SYNTHESIS
    // Two buffers must never be enabled together.
    a_enable_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $countones(en_q) <= 1)
        else $error("tri_bus_arbiter: more than one enable high: %b", en_q);
`endif

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter with N=4, TURN=1, MAX_HOLD=16.
// The driver applies one req value per cycle and queues the hand-computed
// outputs expected after the next rising edge; a monitor pops one entry per
// edge and compares, so stimulus and checking stay decoupled.
module tb_tri_bus_arbiter;

    localparam int N        = 4;
    localparam int TURN     = 1;
    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] en;
    logic [1:0] owner;
    logic       bus_busy;
    logic       timeout;
    logic [1:0] dbg_state;

    // Expected entry: {en, busy, timeout, owner (0 when not busy)}
    logic [7:0] exp_q[$];
    string      name_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;

    tri_bus_arbiter #(
        .N        (N),
        .TURN     (TURN),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .en        (en),
        .owner     (owner),
        .bus_busy  (bus_busy),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Monitor / scoreboard: one comparison per rising edge with a queued entry
    always begin
        logic [7:0] e;
        logic [7:0] a;
        string      nm;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {en, bus_busy, timeout, (bus_busy ? owner : 2'b00)};
            n_checks++;
            if (a === e && $countones(en) <= 1) begin
                n_pass++;
            end else begin
                $display("FAIL %s @%0t: got en=%b busy=%b to=%b own=%0d, expected en=%b busy=%b to=%b own=%0d",
                         nm, $time, a[7:4], a[3], a[2], a[1:0], e[7:4], e[3], e[2], e[1:0]);
            end
        end
    end

    // Driver: apply req for the coming edge and queue the outputs after it
    task automatic step(input logic [3:0] r, input logic [3:0] e_en,
                        input logic [1:0] e_own, input logic e_to, input string nm);
        @(negedge clk);
        req = r;
        exp_q.push_back({e_en, |e_en, e_to, e_own});
        name_q.push_back(nm);
    endtask

    // Direct check that all outputs sit at their reset values
    task automatic check_reset_outputs(input string nm);
        n_checks++;
        if (en === 4'b0000 && bus_busy === 1'b0 && timeout === 1'b0 &&
            owner === 2'b00 && dbg_state === 2'b00) begin
            n_pass++;
        end else begin
            $display("FAIL %s @%0t: got en=%b busy=%b to=%b own=%0d st=%0d, expected all zero",
                     nm, $time, en, bus_busy, timeout, owner, dbg_state);
        end
    endtask

    // Reset pulse asserted between edges, checked before any clock edge
    task automatic do_reset(input string nm);
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b0;
        #1;
        check_reset_outputs(nm);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_values");
        rst_n = 1'b1;

        // Quiet bus: nothing granted, nothing pulses
        for (int i = 0; i < 5; i++) step(4'b0000, 4'b0000, 2'd0, 1'b0, "idle_quiet");

        // Two requesters: 1 wins from pointer 0, then 2 after one gap cycle
        step(4'b0110, 4'b0010, 2'd1, 1'b0, "grant_1");
        step(4'b0110, 4'b0010, 2'd1, 1'b0, "hold_1");
        step(4'b0100, 4'b0000, 2'd0, 1'b0, "release_1_gap");
        step(4'b0100, 4'b0100, 2'd2, 1'b0, "handover_2");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "release_2");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "back_to_idle");

        // All four requesting: forced rotation 0,1,2,3 then 0 again.
        // req[0] dips once during owner 1 so it becomes eligible again.
        do_reset("reset_before_rotation");
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 16; c++) begin
                step((k == 1 && c == 4) ? 4'b1110 : 4'b1111,
                     4'(1 << k), 2'(k), 1'b0, "rotate_hold");
            end
            step(4'b1111, 4'b0000, 2'd0, 1'b1, "rotate_timeout");
        end
        step(4'b1111, 4'b0001, 2'd0, 1'b0, "rotate_back_to_0");
        step(4'b1111, 4'b0001, 2'd0, 1'b0, "rotate_hold_0");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "rotate_release");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "rotate_idle");

        // Lone requester 2 times out and stays masked until it drops req
        for (int c = 0; c < 16; c++) step(4'b0100, 4'b0100, 2'd2, 1'b0, "lone_hold_2");
        step(4'b0100, 4'b0000, 2'd0, 1'b1, "lone_timeout");
        for (int c = 0; c < 4; c++) step(4'b0100, 4'b0000, 2'd0, 1'b0, "lone_masked");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "lone_req_low");
        step(4'b0100, 4'b0100, 2'd2, 1'b0, "lone_regrant");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "lone_release");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "lone_idle");

        // Release on the very edge the hold limit is reached: no pulse, no mask
        for (int c = 0; c < 16; c++) step(4'b0100, 4'b0100, 2'd2, 1'b0, "edge_hold_2");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "edge_release_no_timeout");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "edge_idle");
        step(4'b0100, 4'b0100, 2'd2, 1'b0, "edge_not_masked");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "edge_release");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "edge_idle2");

        // Asynchronous reset during ownership, then pointer restarts at 0
        step(4'b0010, 4'b0010, 2'd1, 1'b0, "pre_reset_grant_1");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset_drop");
        @(negedge clk);
        req   = 4'b0000;
        rst_n = 1'b1;
        step(4'b1010, 4'b0010, 2'd1, 1'b0, "post_reset_ptr0");
        step(4'b1000, 4'b0000, 2'd0, 1'b0, "post_reset_release");
        step(4'b1000, 4'b1000, 2'd3, 1'b0, "post_reset_grant_3");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "post_reset_release_3");
        step(4'b0000, 4'b0000, 2'd0, 1'b0, "final_idle");

        // Let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
